// File: rtl/vend_status_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vend_status_ctrl_pkg : status codes, coin values and state type for the
//                        vending transaction controller.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vend_status_ctrl_pkg;

  typedef logic [1:0] status_t;

  localparam status_t ST_IDLE    = 2'b00;
  localparam status_t ST_FAIL    = 2'b01;
  localparam status_t ST_COLLECT = 2'b10;
  localparam status_t ST_VEND    = 2'b11;

  localparam logic [1:0] c_coin_05_units = 2'd1;
  localparam logic [1:0] c_coin_10_units = 2'd2;

  // The state encoding is the status code itself, so the status output is the state register.
  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_FAIL    = ST_FAIL,
    S_COLLECT = ST_COLLECT,
    S_VEND    = ST_VEND
  } state_t;

  function automatic logic [1:0] coin_value(input logic coin_05, input logic coin_10);
    return (coin_05 ? c_coin_05_units : 2'd0) + (coin_10 ? c_coin_10_units : 2'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vend_status_ctrl_if.sv
// ---------------------------------------------------------------------------
// vend_status_ctrl_if : coin/button inputs and status/dispense/change outputs
//                       of the vending controller.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vend_status_ctrl_if;
  import vend_status_ctrl_pkg::*;

  logic       coin_05;
  logic       coin_10;
  logic       buy_a;
  logic       buy_b;
  logic       cancel;
  status_t    number_zhuangtai;
  logic [7:0] credit;
  logic       dispense_a;
  logic       dispense_b;
  logic [7:0] change;
  logic       change_vld;
  logic       coin_rej;

  modport master (
    output coin_05, coin_10, buy_a, buy_b, cancel,
    input  number_zhuangtai, credit, dispense_a, dispense_b, change, change_vld, coin_rej
  );

  modport slave (
    input  coin_05, coin_10, buy_a, buy_b, cancel,
    output number_zhuangtai, credit, dispense_a, dispense_b, change, change_vld, coin_rej
  );

endinterface

`default_nettype wire

// File: rtl/vend_status_ctrl_timer.sv
// ---------------------------------------------------------------------------
// vend_timer : loadable down-counter; done is high while the count is zero.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vend_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/vend_status_ctrl.sv
// ---------------------------------------------------------------------------
// vend_status_ctrl : vending transaction FSM, credit arithmetic and status
//                    code producer for the beeper/LED drivers.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vend_status_ctrl
  import vend_status_ctrl_pkg::*;
#(
  parameter int unsigned PRICE_A      = 5,
  parameter int unsigned PRICE_B      = 7,
  parameter int unsigned MAX_CREDIT   = 40,
  parameter int unsigned HOLD_CYCLES  = 40_000_000,
  parameter int unsigned IDLE_TIMEOUT = 500_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  vend_status_ctrl_if.slave  bus
);

  localparam int unsigned c_hold_w = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned c_idle_w = $clog2(IDLE_TIMEOUT + 1);

  // Timers load N-1 so that done rises on the N-th cycle after the load edge.
  localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(HOLD_CYCLES - 1);
  localparam logic [c_idle_w-1:0] c_idle_init = c_idle_w'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]          c_price_a   = 8'(PRICE_A);
  localparam logic [7:0]          c_price_b   = 8'(PRICE_B);
  localparam logic [8:0]          c_max_credit = 9'(MAX_CREDIT);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_credit, w_credit_nxt;
  logic [7:0] r_change, w_change_nxt;
  logic       r_change_vld, w_change_vld_nxt;
  logic       r_disp_a, w_disp_a_nxt;
  logic       r_disp_b, w_disp_b_nxt;
  logic       r_coin_rej, w_coin_rej_nxt;

  logic       w_hold_load, w_hold_done;
  logic       w_idle_load, w_idle_done;
  logic [1:0] w_coin_val;
  logic       w_coin;
  logic [8:0] w_sum;
  logic       w_buy;
  logic [7:0] w_price;

  assign w_coin_val = coin_value(bus.coin_05, bus.coin_10);
  assign w_coin     = (w_coin_val != 2'd0);
  assign w_sum      = {1'b0, r_credit} + {7'd0, w_coin_val};
  assign w_buy      = bus.buy_a | bus.buy_b;
  assign w_price    = bus.buy_a ? c_price_a : c_price_b;

  vend_timer #(.WIDTH(c_hold_w)) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_hold_load),
    .load_val (c_hold_init),
    .done     (w_hold_done)
  );

  vend_timer #(.WIDTH(c_idle_w)) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_idle_load),
    .load_val (c_idle_init),
    .done     (w_idle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_credit     <= '0;
      r_change     <= '0;
      r_change_vld <= 1'b0;
      r_disp_a     <= 1'b0;
      r_disp_b     <= 1'b0;
      r_coin_rej   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_credit     <= w_credit_nxt;
      r_change     <= w_change_nxt;
      r_change_vld <= w_change_vld_nxt;
      r_disp_a     <= w_disp_a_nxt;
      r_disp_b     <= w_disp_b_nxt;
      r_coin_rej   <= w_coin_rej_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_credit_nxt     = r_credit;
    w_change_nxt     = '0;
    w_change_vld_nxt = 1'b0;
    w_disp_a_nxt     = 1'b0;
    w_disp_b_nxt     = 1'b0;
    w_coin_rej_nxt   = 1'b0;
    w_hold_load      = 1'b0;
    w_idle_load      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_buy) begin
          w_coin_rej_nxt = w_coin;
          w_hold_load    = 1'b1;
          w_state_nxt    = S_FAIL;
        end else if (w_coin) begin
          w_credit_nxt = w_sum[7:0];
          w_idle_load  = 1'b1;
          w_state_nxt  = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // Inactivity timeout behaves exactly like a cancel press.
        if (bus.cancel || w_idle_done) begin
          w_coin_rej_nxt   = w_coin;
          w_change_nxt     = r_credit;
          w_change_vld_nxt = 1'b1;
          w_credit_nxt     = '0;
          w_state_nxt      = S_IDLE;
        end else if (w_buy) begin
          w_coin_rej_nxt = w_coin;
          w_hold_load    = 1'b1;
          if (r_credit >= w_price) begin
            w_disp_a_nxt     = bus.buy_a;
            w_disp_b_nxt     = ~bus.buy_a;
            w_change_nxt     = r_credit - w_price;
            w_change_vld_nxt = (r_credit != w_price);
            w_credit_nxt     = '0;
            w_state_nxt      = S_VEND;
          end else begin
            w_state_nxt = S_FAIL;
          end
        end else if (w_coin) begin
          if (w_sum <= c_max_credit) begin
            w_credit_nxt = w_sum[7:0];
            w_idle_load  = 1'b1;
          end else begin
            w_coin_rej_nxt = 1'b1;
          end
        end
      end

      S_VEND: begin
        w_coin_rej_nxt = w_coin;
        if (w_hold_done) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_FAIL: begin
        w_coin_rej_nxt = w_coin;
        if (w_hold_done) begin
          w_idle_load = 1'b1;
          w_state_nxt = (r_credit != '0) ? S_COLLECT : S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.number_zhuangtai = r_state;
  assign bus.credit           = r_credit;
  assign bus.change           = r_change;
  assign bus.change_vld       = r_change_vld;
  assign bus.dispense_a       = r_disp_a;
  assign bus.dispense_b       = r_disp_b;
  assign bus.coin_rej         = r_coin_rej;

endmodule

`default_nettype wire

// File: tb/tb_vend_status_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_status_ctrl : directed scenarios plus random coin/button traffic,
//                       checked every cycle against a behavioural model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vend_status_ctrl;

  localparam int H    = 8;
  localparam int T    = 20;
  localparam int PA   = 5;
  localparam int PB   = 7;
  localparam int MAXC = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  vend_status_ctrl_if bus();

  vend_status_ctrl #(
    .PRICE_A      (PA),
    .PRICE_B      (PB),
    .MAX_CREDIT   (MAXC),
    .HOLD_CYCLES  (H),
    .IDLE_TIMEOUT (T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: mode is the status code, held/idle count cycles spent in a state.
  int m_mode, m_credit, m_held, m_idle;
  int e_status, e_credit, e_da, e_db, e_change, e_vld, e_rej;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task model_step();
    int  val;
    int  p;
    bit  coin;
    val  = int'(bus.coin_05) + 2 * int'(bus.coin_10);
    coin = (val != 0);
    e_da = 0; e_db = 0; e_change = 0; e_vld = 0; e_rej = 0;
    if (!rst_n) begin
      m_mode = 0; m_credit = 0; m_held = 0; m_idle = 0;
    end else begin
      case (m_mode)
        0: begin
          if (bus.buy_a || bus.buy_b) begin
            e_rej = coin; m_mode = 1; m_held = 0;
          end else if (coin) begin
            m_credit += val; m_mode = 2; m_idle = 0;
          end
        end
        2: begin
          if (bus.cancel || (m_idle + 1 >= T)) begin
            e_change = m_credit; e_vld = 1; m_credit = 0; m_mode = 0; e_rej = coin;
          end else if (bus.buy_a || bus.buy_b) begin
            p = bus.buy_a ? PA : PB;
            e_rej = coin; m_held = 0;
            if (m_credit >= p) begin
              e_da = bus.buy_a ? 1 : 0;
              e_db = bus.buy_a ? 0 : 1;
              e_change = m_credit - p;
              e_vld = (m_credit != p) ? 1 : 0;
              m_credit = 0; m_mode = 3;
            end else begin
              m_mode = 1;
            end
          end else if (coin && (m_credit + val <= MAXC)) begin
            m_credit += val; m_idle = 0;
          end else begin
            e_rej = coin; m_idle++;
          end
        end
        default: begin
          e_rej = coin;
          m_held++;
          if (m_held == H) begin
            m_mode = (m_mode == 3 || m_credit == 0) ? 0 : 2;
            m_idle = 0;
          end
        end
      endcase
    end
    e_status = m_mode;
    e_credit = m_credit;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("status",     32'(bus.number_zhuangtai), e_status);
      chk("credit",     32'(bus.credit),           e_credit);
      chk("dispense_a", 32'(bus.dispense_a),       e_da);
      chk("dispense_b", 32'(bus.dispense_b),       e_db);
      chk("change",     32'(bus.change),           e_change);
      chk("change_vld", 32'(bus.change_vld),       e_vld);
      chk("coin_rej",   32'(bus.coin_rej),         e_rej);
    end
  end

  task automatic drive(input bit c05, input bit c10, input bit ba, input bit bb, input bit can);
    bus.coin_05 = c05;
    bus.coin_10 = c10;
    bus.buy_a   = ba;
    bus.buy_b   = bb;
    bus.cancel  = can;
  endtask

  // Returns shortly after the edge that sampled the inputs, so the response is visible.
  task automatic step(input bit c05, input bit c10, input bit ba, input bit bb, input bit can);
    @(negedge clk);
    drive(c05, c10, ba, bb, can);
    @(posedge clk);
    #2;
  endtask

  task automatic quiet(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_status", 32'(bus.number_zhuangtai), 0);
    chk("rst_credit", 32'(bus.credit), 0);
    rst_n = 1'b1;

    // Successful purchase of A with one unit of change
    repeat (3) step(0, 1, 0, 0, 0);
    chk("a_credit6", 32'(bus.credit), 6);
    chk("a_collect", 32'(bus.number_zhuangtai), 2);
    step(0, 0, 1, 0, 0);
    chk("a_disp",   32'(bus.dispense_a), 1);
    chk("a_change", 32'(bus.change), 1);
    chk("a_vld",    32'(bus.change_vld), 1);
    chk("a_vend",   32'(bus.number_zhuangtai), 3);
    chk("a_credit0", 32'(bus.credit), 0);
    quiet(7);
    chk("a_hold_end", 32'(bus.number_zhuangtai), 3);
    quiet(1);
    chk("a_idle", 32'(bus.number_zhuangtai), 0);

    // Insufficient credit for B: fail hold then back to collecting
    repeat (2) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("b_fail",   32'(bus.number_zhuangtai), 1);
    chk("b_credit", 32'(bus.credit), 2);
    chk("b_nodisp", 32'(bus.dispense_b), 0);
    quiet(7);
    chk("b_hold_end", 32'(bus.number_zhuangtai), 1);
    quiet(1);
    chk("b_collect", 32'(bus.number_zhuangtai), 2);
    chk("b_credit_kept", 32'(bus.credit), 2);
    step(0, 0, 0, 0, 1);
    chk("b_refund", 32'(bus.change), 2);

    // Credit ceiling
    repeat (20) step(0, 1, 0, 0, 0);
    chk("c_credit40", 32'(bus.credit), 40);
    step(1, 0, 0, 0, 0);
    chk("c_rej",      32'(bus.coin_rej), 1);
    chk("c_credit_hold", 32'(bus.credit), 40);
    step(0, 0, 0, 0, 1);
    chk("c_refund", 32'(bus.change), 40);

    // Coin + buy + cancel together: cancel wins, coin returned
    repeat (2) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1);
    chk("d_change", 32'(bus.change), 4);
    chk("d_vld",    32'(bus.change_vld), 1);
    chk("d_rej",    32'(bus.coin_rej), 1);
    chk("d_credit", 32'(bus.credit), 0);
    chk("d_status", 32'(bus.number_zhuangtai), 0);
    chk("d_nodisp", 32'(bus.dispense_a), 0);

    // Inactivity timeout refund
    step(1, 0, 0, 0, 0);
    quiet(T - 1);
    chk("e_not_yet", 32'(bus.change_vld), 0);
    chk("e_collect", 32'(bus.number_zhuangtai), 2);
    quiet(1);
    chk("e_vld",    32'(bus.change_vld), 1);
    chk("e_change", 32'(bus.change), 1);
    chk("e_idle",   32'(bus.number_zhuangtai), 0);

    // Asynchronous reset while vending, between clock edges
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("f_status", 32'(bus.number_zhuangtai), 0);
    chk("f_disp",   32'(bus.dispense_a), 0);
    chk("f_vld",    32'(bus.change_vld), 0);
    chk("f_change", 32'(bus.change), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset();
      end else if (r < 3) begin
        quiet(T + 2);
      end else begin
        step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
             $urandom_range(0, 99) < 6,  $urandom_range(0, 99) < 6,
             $urandom_range(0, 99) < 4);
      end
    end

    quiet(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
